// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared encodings and segment decode for the stopwatch display path
// Contents:
//   status_e      stopwatch status encodings (reserved code behaves as idle)
//   conv_state_e  BCD converter sequencing states
//   SEG_*         active-low segment patterns {g,f,e,d,c,b,a}
//   DIGIT_DASH    internal digit code that renders as a dash
//   seg_decode    digit code -> segment pattern
package stopwatch_pkg;

    typedef enum logic [1:0] {
        STATUS_IDLE    = 2'b00,
        STATUS_RUNNING = 2'b01,
        STATUS_PAUSED  = 2'b10,
        STATUS_RESV    = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        CONV_IDLE   = 2'b00,
        CONV_SHIFT  = 2'b01,
        CONV_COMMIT = 2'b10
    } conv_state_e;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Display registers hold 4-bit codes; 0..9 are digits, this one is a dash.
    localparam logic [3:0] DIGIT_DASH = 4'hA;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        case (digit)
            4'd0:       seg_decode = SEG_0;
            4'd1:       seg_decode = SEG_1;
            4'd2:       seg_decode = SEG_2;
            4'd3:       seg_decode = SEG_3;
            4'd4:       seg_decode = SEG_4;
            4'd5:       seg_decode = SEG_5;
            4'd6:       seg_decode = SEG_6;
            4'd7:       seg_decode = SEG_7;
            4'd8:       seg_decode = SEG_8;
            4'd9:       seg_decode = SEG_9;
            DIGIT_DASH: seg_decode = SEG_DASH;
            default:    seg_decode = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - 8-bit sequential double-dabble converter, one shift per cycle
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   start      load bin and begin an 8-cycle conversion
//   bin        binary input, sampled on the start cycle
//   busy       shifting in progress
//   done       high during the final shift cycle; BCD outputs are valid the cycle after
//   bcd_tens   tens digit (only meaningful for inputs <= 99)
//   bcd_ones   ones digit
module bin2bcd_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] bin,
    output logic       busy,
    output logic       done,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones
);

    logic [7:0] sh_q, sh_d;
    logic [7:0] bcd_q, bcd_d;
    logic [2:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic [3:0] ones_adj, tens_adj;

    always_comb begin
        sh_d     = sh_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        ones_adj = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
        tens_adj = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
        if (start) begin
            sh_d   = bin;
            bcd_d  = 8'h00;
            cnt_d  = 3'd0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            // Hundreds carry out of the tens digit is dropped; the caller
            // clamps values above 99, and lower digits are unaffected.
            {bcd_d, sh_d} = {tens_adj[2:0], ones_adj, sh_q, 1'b0};
            cnt_d         = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q   <= 8'h00;
            bcd_q  <= 8'h00;
            cnt_q  <= 3'd0;
            busy_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign done     = busy_q && (cnt_q == 3'd7);
    assign bcd_tens = bcd_q[7:4];
    assign bcd_ones = bcd_q[3:0];

endmodule

// File: rtl/stopwatch_display_mux.sv
// rtl/stopwatch_display_mux.sv - MM:SS BCD conversion, 4-digit multiplexed 7-seg drive with pause blink
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   minutes    binary minutes 0..99 (larger shows dashes)
//   seconds    binary seconds 0..59 (larger shows dashes)
//   status     00 idle, 01 running, 10 paused (blinks), 11 treated as idle
//   an         active-low digit enables, an[0] = seconds ones
//   seg        active-low segments {g,f,e,d,c,b,a}
//   dp         active-low decimal point, lit on digit 2 only
//   busy       BCD conversion in progress
module stopwatch_display_mux
    import stopwatch_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] minutes,
    input  logic [5:0] seconds,
    input  logic [1:0] status,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       busy
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

    conv_state_e   state_q, state_d;
    logic [7:0]    cap_min_q, cap_min_d;
    logic [5:0]    cap_sec_q, cap_sec_d;
    logic [15:0]   disp_q, disp_d;
    logic [1:0]    idx_q, idx_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic       start;
    logic       min_busy, min_done, sec_busy, sec_done;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       paused, blank;
    logic [3:0] digit;

    // The converters load straight from the inputs on the same edge the
    // top captures them, so captured value and converted value always match.
    assign start = (state_q == CONV_IDLE) &&
                   ({minutes, seconds} != {cap_min_q, cap_sec_q});

    bin2bcd_seq u_min_conv (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin      (minutes),
        .busy     (min_busy),
        .done     (min_done),
        .bcd_tens (min_tens),
        .bcd_ones (min_ones)
    );

    bin2bcd_seq u_sec_conv (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin      ({2'b00, seconds}),
        .busy     (sec_busy),
        .done     (sec_done),
        .bcd_tens (sec_tens),
        .bcd_ones (sec_ones)
    );

    assign busy = min_busy || sec_busy || (state_q == CONV_COMMIT);

    always_comb begin
        state_d   = state_q;
        cap_min_d = cap_min_q;
        cap_sec_d = cap_sec_q;
        disp_d    = disp_q;
        case (state_q)
            CONV_IDLE: begin
                if (start) begin
                    cap_min_d = minutes;
                    cap_sec_d = seconds;
                    state_d   = CONV_SHIFT;
                end
            end
            CONV_SHIFT: begin
                if (min_done && sec_done) begin
                    state_d = CONV_COMMIT;
                end
            end
            CONV_COMMIT: begin
                // All four digits update together so no torn value is shown.
                disp_d[15:12] = (cap_min_q > 8'd99) ? DIGIT_DASH : min_tens;
                disp_d[11:8]  = (cap_min_q > 8'd99) ? DIGIT_DASH : min_ones;
                disp_d[7:4]   = (cap_sec_q > 6'd59) ? DIGIT_DASH : sec_tens;
                disp_d[3:0]   = (cap_sec_q > 6'd59) ? DIGIT_DASH : sec_ones;
                state_d       = CONV_IDLE;
            end
            default: state_d = CONV_IDLE;
        endcase
    end

    assign paused = (status == STATUS_PAUSED);
    // Status is used directly so leaving pause relights on the next edge.
    assign blank  = paused && phase_q;
    assign digit  = disp_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        rcnt_d  = (rcnt_q == REFRESH_LAST) ? '0 : rcnt_q + 1'b1;
        idx_d   = (rcnt_q == REFRESH_LAST) ? idx_q + 2'd1 : idx_q;
        bcnt_d  = '0;
        phase_d = 1'b0;
        if (paused) begin
            bcnt_d  = (bcnt_q == BLINK_LAST) ? '0 : bcnt_q + 1'b1;
            phase_d = (bcnt_q == BLINK_LAST) ? ~phase_q : phase_q;
        end
        an_d  = blank ? 4'hF : ~(4'b0001 << idx_q);
        seg_d = seg_decode(digit);
        dp_d  = !((idx_q == 2'd2) && !blank);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CONV_IDLE;
            cap_min_q <= 8'h00;
            cap_sec_q <= 6'h00;
            disp_q    <= 16'h0000;
            idx_q     <= 2'd0;
            rcnt_q    <= '0;
            bcnt_q    <= '0;
            phase_q   <= 1'b0;
            an_q      <= 4'hF;
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cap_min_q <= cap_min_d;
            cap_sec_q <= cap_sec_d;
            disp_q    <= disp_d;
            idx_q     <= idx_d;
            rcnt_q    <= rcnt_d;
            bcnt_q    <= bcnt_d;
            phase_q   <= phase_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule
